mem_stream_ctrl: RTL and testbench
==================================

// Module: mem_stream_ctrl
// PURPOSE
//  Upstream controller for the single-port byte memory (clk/read/write/addr/data_in/data_out).
//  LOAD phase: accepts a valid/ready byte stream (e.g. ASCII text) and writes it to consecutive
//  addresses from 0. DRAIN phase: on start, reads back words 0..count-1 in order and presents
//  them on a valid/ready output stream. Replaces ad-hoc file-driven write/read sequencing.
// PARAMETERS
//  ADDR_WIDTH   9    memory address width
//  DATA_WIDTH   8    memory/stream word width
//  MEM_DEPTH    512  number of words; must be <= 2**ADDR_WIDTH
//  RD_LATENCY   1    clocks from mem_read sampled high to data_out valid (1..3)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst          in   1              asynchronous, active-high reset
//  in_valid     in   1              input byte valid
//  in_ready     out  1              controller can accept a byte
//  in_data      in   DATA_WIDTH     input byte
//  start        in   1              one-cycle pulse: begin DRAIN of stored words
//  clear        in   1              one-cycle pulse: discard stored count (IDLE/LOAD only)
//  out_valid    out  1              read-back word valid
//  out_ready    in   1              downstream accepts word
//  out_data     out  DATA_WIDTH     read-back word
//  count        out  ADDR_WIDTH+1   words stored (0..MEM_DEPTH)
//  full         out  1              count == MEM_DEPTH
//  busy         out  1              DRAIN in progress
//  done         out  1              one-cycle pulse when DRAIN finishes
//  mem_write    out  1              to memory write
//  mem_read     out  1              to memory read
//  mem_addr     out  ADDR_WIDTH     to memory addr
//  mem_wdata    out  DATA_WIDTH     to memory data_in
//  mem_rdata    in   DATA_WIDTH     from memory data_out
// BEHAVIOUR
//  - Reset: state=LOAD, count=0, all outputs 0 except in_ready=1; any in-flight op abandoned.
//  - All outputs registered except in_ready (combinational: state==LOAD && !full).
//  - LOAD: byte accepted on edge with in_valid&&in_ready; next cycle mem_write=1 for exactly
//    1 clk, mem_addr=count(old), mem_wdata=in_data; count increments on accept edge.
//    Back-to-back accepts allowed: one write per clk. full=1 blocks accepts; no wrap.
//  - clear in LOAD: count->0 next edge; same-cycle accept is dropped (clear wins).
//  - start in LOAD: state->DRAIN, busy=1, rd_ptr=0. Same-cycle in_valid not accepted
//    (in_ready forced 0 that cycle). count==0: no reads, done pulses next cycle, back to LOAD.
//  - DRAIN substates: ISSUE (mem_read=1, mem_addr=rd_ptr, 1 clk) -> WAIT (RD_LATENCY-1 clks)
//    -> CAPTURE (out_data<=mem_rdata, out_valid=1) -> HOLD until out_ready; on handshake
//    out_valid=0, rd_ptr++; rd_ptr==count -> done=1 one clk, busy=0, state LOAD; else ISSUE.
//  - out_data/out_valid stable while out_valid && !out_ready.
//  - mem_read and mem_write never both high. start/clear ignored while busy.
//  - count retained after DRAIN; further LOAD appends at address count.
//  - Min throughput DRAIN: one word per RD_LATENCY+2 clks with out_ready held high.
// STRUCTURE
//  - Package mem_stream_pkg: state enum {LOAD, ISSUE, WAIT, CAPTURE, HOLD},
//    RD_LATENCY_MAX=3, count width helper function.
//  - Single module, no sub-modules; latency counter width $clog2(RD_LATENCY_MAX+1).
//  - Bench instantiates mem_stream_ctrl + existing memory, ports connected 1:1.
// TESTING
//  1 Load "HELLO" (72,69,76,76,79), in_valid continuous -> 5 consecutive mem_write clks,
//    addr 0..4, count=5, no mem_read.
//  2 start, out_ready=1 -> out_data 72,69,76,76,79 in order, done once after 5th, busy low.
//  3 DRAIN with out_ready toggling 1-of-3 cycles -> out_data held stable, no loss/duplicate.
//  4 Stream 513 bytes -> full=1 at count=512, in_ready=0, byte 513 never written.
//  5 start with count=0 -> done pulse next clk, no mem_read; clear+in_valid same clk -> count=0.
//  6 Assert rst mid-DRAIN (addr 2) -> all outputs 0 async, count=0, in_ready=1 after release.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream controller.
package mem_stream_pkg;

  typedef enum logic [2:0] {
    LOAD,
    ISSUE,
    WAIT,
    CAPTURE,
    HOLD
  } state_t;

  localparam int unsigned RD_LATENCY_MAX = 3;
  localparam int unsigned LAT_W          = $clog2(RD_LATENCY_MAX + 1);

  // Word count spans 0..2**addr_width inclusive, so it needs one extra bit.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/mem_stream_ctrl.sv
// Upstream controller for a single-port byte memory: loads a valid/ready byte
// stream into consecutive addresses, then drains the stored words in order
// onto a valid/ready output stream.
module mem_stream_ctrl
  import mem_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  start,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned       CNT_W     = count_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(MEM_DEPTH);
  localparam logic [LAT_W-1:0]  WAIT_LAST = LAT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   rd_ptr_inc;
  logic [CNT_W-1:0]   count_inc;
  logic [LAT_W-1:0]   lat_cnt;
  logic               accept;
  logic               last_word;

  // A start pulse takes the slot, so no byte may be accepted alongside it.
  assign in_ready   = (state == LOAD) && !full && !start;
  assign accept     = in_valid && in_ready && !clear;
  assign rd_ptr_inc = rd_ptr + CNT_W'(1);
  assign count_inc  = count + CNT_W'(1);
  assign last_word  = (rd_ptr_inc == count);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state selection for the load/drain sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (start && (count != '0)) state_nxt = ISSUE;
      ISSUE:   state_nxt = (RD_LATENCY > 1) ? WAIT : CAPTURE;
      WAIT:    if (lat_cnt == WAIT_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = last_word ? LOAD : ISSUE;
      default: state_nxt = LOAD;
    endcase
  end

  // Registered outputs, counters and memory command generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_ptr    <= '0;
      lat_cnt   <= '0;
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      done      <= 1'b0;
      case (state)
        LOAD: begin
          // start outranks clear; an empty store finishes immediately.
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              busy     <= 1'b1;
              rd_ptr   <= '0;
              mem_read <= 1'b1;
              mem_addr <= '0;
            end
          end else if (clear) begin
            count <= '0;
            full  <= 1'b0;
          end else if (accept) begin
            mem_write <= 1'b1;
            mem_addr  <= count[ADDR_WIDTH-1:0];
            mem_wdata <= in_data;
            count     <= count_inc;
            full      <= (count_inc == DEPTH_C);
          end
        end
        ISSUE:   lat_cnt <= '0;
        WAIT:    lat_cnt <= lat_cnt + LAT_W'(1);
        CAPTURE: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rd_ptr    <= rd_ptr_inc;
            if (last_word) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= rd_ptr_inc[ADDR_WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Scoreboard bench for mem_stream_ctrl with a behavioural byte memory.
module tb_mem_stream_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned RDL   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          start = 1'b0, clear = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          full, busy, done, mem_write, mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_stream_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .RD_LATENCY (RDL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .start     (start),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .busy      (busy),
    .done      (done),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port memory with RDL clocks from read sample to data_out.
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] rpipe [RDL];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  rpipe[0] <= mem[mem_addr];
    for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RDL-1];

  // Reference model and scoreboard state.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           wr_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int unsigned   model_count = 0;
  int unsigned   n_cmp = 0, n_bad = 0, n_reads = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes/reads whenever the DUT presents them.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      wr_t w;
      if (mem_read) n_reads++;
      if (done) done_cnt++;
      check("rw_exclusive", mem_read && mem_write, 0);
      if (mem_write) begin
        check("write_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_addr", mem_addr, w.a);
          check("wr_data", mem_wdata, w.d);
        end
      end
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        check("read_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("out_data", out_data, rd_q.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Offer one byte for one clock; the model decides whether it is taken.
  task automatic send(input logic [DW-1:0] b, input bit clr);
    wr_t w;
    in_valid = 1'b1; in_data = b; clear = clr;
    #1;
    check("in_ready", in_ready, model_count < DEPTH);
    if (clr) begin
      model_count = 0;
    end else if (model_count < DEPTH) begin
      model_mem[model_count] = b;
      w.a = AW'(model_count);
      w.d = b;
      wr_q.push_back(w);
      model_count++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
    model_count = 0;
  endtask

  // mode 0: ready always, 1: ready one cycle in three, 2: random ready.
  task automatic drain(input int unsigned mode);
    int unsigned d0 = done_cnt;
    int unsigned k  = 0;
    for (int unsigned i = 0; i < model_count; i++) rd_q.push_back(model_mem[i]);
    start = 1'b1; cyc(); start = 1'b0;
    if (model_count == 0) begin
      @(negedge clk);
      check("done_next_clk", done, 1);
      check("busy_empty", busy, 0);
      @(posedge clk); #1;
    end
    while (done_cnt == d0 && k < 30 * model_count + 20) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 3) == 0) : 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    check("drain_finished", done_cnt != d0, 1);
    out_ready = 1'b0;
    cyc(); cyc();
    check("done_once", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check("rd_all_seen", rd_q.size(), 0);
    check("count_kept", count, model_count);
  endtask

  initial begin
    logic [DW-1:0] hello [5];
    int unsigned   r0, len, hit;
    hello[0] = 8'd72; hello[1] = 8'd69; hello[2] = 8'd76; hello[3] = 8'd76; hello[4] = 8'd79;

    // Reset state.
    #1;
    check("rst_ctrl", {out_valid, busy, done, full, mem_write, mem_read, count}, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();

    // HELLO load: five back-to-back writes, no reads.
    r0 = n_reads;
    for (int i = 0; i < 5; i++) send(hello[i], 1'b0);
    cyc();
    check("hello_count", count, 5);
    check("hello_writes_done", wr_q.size(), 0);
    check("hello_no_read", n_reads - r0, 0);

    // Drain with ready held high, then with sparse ready.
    drain(0);
    drain(1);

    // Random appends and random-ready drains.
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 20);
      for (int unsigned i = 0; i < len; i++) begin
        send(DW'($urandom), 1'b0);
        if ($urandom_range(0, 2) == 0) cyc();
      end
      drain(2);
    end

    // Fill to capacity; the 513th byte must be refused.
    do_clear();
    for (int i = 0; i < 513; i++) send(DW'($urandom), 1'b0);
    cyc();
    check("full_count", count, DEPTH);
    check("full_flag", full, 1);
    check("full_in_ready", in_ready, 0);
    drain(2);

    // Empty drain, then clear racing an offered byte.
    do_clear();
    check("clear_count", count, 0);
    r0 = n_reads;
    drain(0);
    check("empty_no_read", n_reads - r0, 0);
    for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b0);
    send(8'hA5, 1'b1);
    cyc();
    check("clear_wins", count, 0);
    check("clear_no_write", wr_q.size(), 0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 6; i++) send(DW'($urandom), 1'b0);
    for (int unsigned i = 0; i < model_count; i++) rd_q.push_back(model_mem[i]);
    out_ready = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 60 && hit == 0; i++) begin
      @(negedge clk);
      if (mem_read && mem_addr == 2) hit = 1;
    end
    check("reached_addr2", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("async_ctrl", {out_valid, busy, done, full, mem_write, mem_read, count}, 0);
    check("async_data", {mem_addr, mem_wdata, out_data}, 0);
    rd_q.delete();
    model_count = 0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("post_rst_count", count, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Recovery after reset.
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1'b0);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on total simulation time.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
